// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl_if
// Purpose  : Bundles the signals of alu_issue_ctrl into one interface. It
//            covers the instruction/operand input channel, the ALU drive and
//            sample bus, and the result/branch output channel.
// Modports : slave  - the controller (alu_issue_ctrl)
//            master - the environment (decode/regfile, ALU, writeback)
// Ports    : inst_*, instr_in, pc_in, rs*_data_in, flush_in  (to controller)
//            alu_in1/in2/sel_out                              (to ALU)
//            alu_result/lsr/eql_in                            (from ALU)
//            res_*, wb_*, branch_*, illegal_out               (to consumer)
// Revision : 1.0  initial release
// ============================================================================
interface alu_issue_ctrl_if;
  logic        inst_valid_in;
  logic        inst_ready_out;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic [31:0] rs1_data_in;
  logic [31:0] rs2_data_in;
  logic        flush_in;
  logic [31:0] alu_in1_out;
  logic [31:0] alu_in2_out;
  logic [3:0]  alu_sel_out;
  logic [31:0] alu_result_in;
  logic        alu_lsr_in;
  logic        alu_eql_in;
  logic        res_valid_out;
  logic        res_ready_in;
  logic        wb_en_out;
  logic [4:0]  wb_rd_out;
  logic [31:0] wb_data_out;
  logic        branch_taken_out;
  logic [31:0] branch_target_out;
  logic        illegal_out;

  modport slave (
    input  inst_valid_in, instr_in, pc_in, rs1_data_in, rs2_data_in, flush_in,
    input  alu_result_in, alu_lsr_in, alu_eql_in, res_ready_in,
    output inst_ready_out, alu_in1_out, alu_in2_out, alu_sel_out,
    output res_valid_out, wb_en_out, wb_rd_out, wb_data_out,
    output branch_taken_out, branch_target_out, illegal_out
  );

  modport master (
    output inst_valid_in, instr_in, pc_in, rs1_data_in, rs2_data_in, flush_in,
    output alu_result_in, alu_lsr_in, alu_eql_in, res_ready_in,
    input  inst_ready_out, alu_in1_out, alu_in2_out, alu_sel_out,
    input  res_valid_out, wb_en_out, wb_rd_out, wb_data_out,
    input  branch_taken_out, branch_target_out, illegal_out
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Execute-stage controller for a shared RV32I ALU. It decodes the
//            OP, OP-IMM and BRANCH instruction classes and drives registered
//            operands and a select code to the ALU. One cycle later it samples
//            the result and flags, then presents either a writeback result or
//            a resolved branch with a valid/ready handshake.
// Ports    : clk, rst (sync, active-high), bus (alu_issue_ctrl_if.slave)
// Revision : 1.0  initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic       clk,
  input  wire logic       rst,
  alu_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [6:0] c_op_reg = 7'b0110011;
  localparam logic [6:0] c_op_imm = 7'b0010011;
  localparam logic [6:0] c_op_br  = 7'b1100011;

  localparam logic [1:0] c_k_alu = 2'd0;
  localparam logic [1:0] c_k_br  = 2'd1;
  localparam logic [1:0] c_k_ill = 2'd2;

  state_t            r_state, w_state_nxt;

  logic [XLEN-1:0]   r_alu_in1, r_alu_in2;
  logic [3:0]        r_alu_sel;
  logic [1:0]        r_kind;
  logic [4:0]        r_rd;
  logic              r_br_eq;
  logic              r_br_inv;
  logic [XLEN-1:0]   r_tgt;

  logic              r_wb_en;
  logic [4:0]        r_wb_rd;
  logic [XLEN-1:0]   r_wb_data;
  logic              r_taken;
  logic              r_illegal;
  logic [XLEN-1:0]   r_target;

  logic [6:0]        w_opcode;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [XLEN-1:0]   w_in1, w_in2;
  logic [3:0]        w_sel;
  logic [1:0]        w_kind;
  logic [XLEN-1:0]   w_bimm;
  logic              w_accept;

  assign w_opcode = bus.instr_in[6:0];
  assign w_f3     = bus.instr_in[14:12];
  assign w_f7     = bus.instr_in[31:25];
  assign w_bimm   = {{19{bus.instr_in[31]}}, bus.instr_in[31], bus.instr_in[7],
                     bus.instr_in[30:25], bus.instr_in[11:8], 1'b0};

  // Instruction decode. Anything not matched stays illegal with sel 0000.
  always_comb begin
    w_in1  = bus.rs1_data_in;
    w_in2  = bus.rs2_data_in;
    w_sel  = 4'b0000;
    w_kind = c_k_ill;
    case (w_opcode)
      c_op_reg: begin
        if (w_f7 == 7'b0000000 ||
            (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
          w_kind = c_k_alu;
          w_sel  = {bus.instr_in[30], w_f3};
        end
      end
      c_op_imm: begin
        w_in2 = {{20{bus.instr_in[31]}}, bus.instr_in[31:20]};
        case (w_f3)
          3'b001: begin
            if (w_f7 == 7'b0000000) begin
              w_kind = c_k_alu;
              w_sel  = 4'b0001;
            end
          end
          3'b101: begin
            if (w_f7 == 7'b0000000 || w_f7 == 7'b0100000) begin
              w_kind = c_k_alu;
              w_sel  = {bus.instr_in[30], 3'b101};
            end
          end
          default: begin
            // imm[11:5] is ordinary immediate data here, so bit 30 must not
            // leak into the select.
            w_kind = c_k_alu;
            w_sel  = {1'b0, w_f3};
          end
        endcase
      end
      c_op_br: begin
        case (w_f3)
          3'b000, 3'b001: begin w_kind = c_k_br; w_sel = 4'b0100; end
          3'b100, 3'b101: begin w_kind = c_k_br; w_sel = 4'b0010; end
          3'b110, 3'b111: begin w_kind = c_k_br; w_sel = 4'b0011; end
          default:        begin w_kind = c_k_ill; w_sel = 4'b0000; end
        endcase
      end
      default: ;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && bus.inst_valid_in && !bus.flush_in;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_DONE;
      S_DONE:  if (bus.res_ready_in) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Flush overrides any pending handshake: the result is dropped.
    if (bus.flush_in) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush_in) begin
      r_alu_in1 <= '0;
      r_alu_in2 <= '0;
      r_alu_sel <= 4'b0000;
      r_kind    <= c_k_alu;
      r_rd      <= 5'd0;
      r_br_eq   <= 1'b0;
      r_br_inv  <= 1'b0;
      r_tgt     <= RESET_PC;
      r_wb_en   <= 1'b0;
      r_wb_rd   <= 5'd0;
      r_wb_data <= '0;
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
      r_target  <= RESET_PC;
    end else begin
      if (w_accept) begin
        r_alu_in1 <= w_in1;
        r_alu_in2 <= w_in2;
        r_alu_sel <= w_sel;
        r_kind    <= w_kind;
        r_rd      <= bus.instr_in[11:7];
        // funct3[2]=0 selects BEQ/BNE (equal flag); funct3[0] inverts.
        r_br_eq   <= ~w_f3[2];
        r_br_inv  <= w_f3[0];
        r_tgt     <= (w_kind == c_k_br) ? (bus.pc_in + w_bimm) : RESET_PC;
      end
      if (r_state == S_EXEC) begin
        r_wb_data <= bus.alu_result_in;
        r_wb_rd   <= r_rd;
        r_wb_en   <= (r_kind == c_k_alu) && (r_rd != 5'd0);
        r_illegal <= (r_kind == c_k_ill);
        r_taken   <= (r_kind == c_k_br) &&
                     ((r_br_eq ? bus.alu_eql_in : bus.alu_lsr_in) ^ r_br_inv);
        r_target  <= r_tgt;
      end
    end
  end

  assign bus.inst_ready_out    = (r_state == S_IDLE) && !bus.flush_in;
  assign bus.res_valid_out     = (r_state == S_DONE);
  assign bus.alu_in1_out       = r_alu_in1;
  assign bus.alu_in2_out       = r_alu_in2;
  assign bus.alu_sel_out       = r_alu_sel;
  assign bus.wb_en_out         = r_wb_en;
  assign bus.wb_rd_out         = r_wb_rd;
  assign bus.wb_data_out       = r_wb_data;
  assign bus.branch_taken_out  = r_taken;
  assign bus.branch_target_out = r_target;
  assign bus.illegal_out       = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Purpose  : Directed self-checking bench for alu_issue_ctrl. It provides a
//            behavioural RV32I ALU on the ALU bus and runs one task per
//            scenario against hand-computed expected values.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_issue_ctrl_if bus();

  alu_issue_ctrl #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference ALU: combinational from the controller's registered operands.
  always_comb begin
    case (bus.alu_sel_out)
      4'b0000: bus.alu_result_in = bus.alu_in1_out + bus.alu_in2_out;
      4'b1000: bus.alu_result_in = bus.alu_in1_out - bus.alu_in2_out;
      4'b0001: bus.alu_result_in = bus.alu_in1_out << bus.alu_in2_out[4:0];
      4'b0010: bus.alu_result_in = {31'd0, $signed(bus.alu_in1_out) < $signed(bus.alu_in2_out)};
      4'b0011: bus.alu_result_in = {31'd0, bus.alu_in1_out < bus.alu_in2_out};
      4'b0100: bus.alu_result_in = bus.alu_in1_out ^ bus.alu_in2_out;
      4'b0101: bus.alu_result_in = bus.alu_in1_out >> bus.alu_in2_out[4:0];
      4'b1101: bus.alu_result_in = $unsigned($signed(bus.alu_in1_out) >>> bus.alu_in2_out[4:0]);
      4'b0110: bus.alu_result_in = bus.alu_in1_out | bus.alu_in2_out;
      4'b0111: bus.alu_result_in = bus.alu_in1_out & bus.alu_in2_out;
      default: bus.alu_result_in = 32'd0;
    endcase
    bus.alu_lsr_in = (bus.alu_sel_out == 4'b0011) ? (bus.alu_in1_out < bus.alu_in2_out)
                   : ($signed(bus.alu_in1_out) < $signed(bus.alu_in2_out));
    bus.alu_eql_in = (bus.alu_in1_out == bus.alu_in2_out);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction and holds it for exactly the accepting edge.
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b);
    int w = 0;
    while (!bus.inst_ready_out && w < 20) begin tick(); w++; end
    if (!bus.inst_ready_out) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_wait ready=%b required 1", bus.inst_ready_out);
    end
    bus.instr_in = ins; bus.pc_in = pc; bus.rs1_data_in = a; bus.rs2_data_in = b;
    bus.inst_valid_in = 1'b1;
    tick();
    bus.inst_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    n_cmp++; if (bus.res_valid_out !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", bus.res_valid_out); end
    n_cmp++; if (bus.inst_ready_out !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%b exp=1", bus.inst_ready_out); end
    n_cmp++; if (bus.branch_target_out !== 32'h0) begin n_bad++; $display("FAIL rst_target got=%h exp=0", bus.branch_target_out); end
    n_cmp++; if ({bus.wb_en_out, bus.alu_sel_out, bus.alu_in1_out} !== 37'd0) begin n_bad++; $display("FAIL rst_outs got=%h exp=0", {bus.wb_en_out, bus.alu_sel_out, bus.alu_in1_out}); end
  endtask

  task automatic test_add();
    bus.res_ready_in = 1'b1;
    issue(32'h002081B3, 32'h40, 32'd5, 32'd7);        // ADD x3,x1,x2
    n_cmp++; if (bus.res_valid_out !== 1'b0) begin n_bad++; $display("FAIL add_exec_valid got=%b exp=0", bus.res_valid_out); end
    n_cmp++; if (bus.alu_sel_out !== 4'b0000) begin n_bad++; $display("FAIL add_sel got=%b exp=0000", bus.alu_sel_out); end
    n_cmp++; if (bus.inst_ready_out !== 1'b0) begin n_bad++; $display("FAIL add_exec_ready got=%b exp=0", bus.inst_ready_out); end
    tick();
    n_cmp++; if (bus.res_valid_out !== 1'b1) begin n_bad++; $display("FAIL add_valid got=%b exp=1", bus.res_valid_out); end
    n_cmp++; if ({bus.wb_en_out, bus.wb_rd_out} !== {1'b1, 5'd3}) begin n_bad++; $display("FAIL add_wb got=%b/%0d exp=1/3", bus.wb_en_out, bus.wb_rd_out); end
    n_cmp++; if (bus.wb_data_out !== 32'd12) begin n_bad++; $display("FAIL add_data got=%h exp=%h", bus.wb_data_out, 32'd12); end
    n_cmp++; if ({bus.illegal_out, bus.branch_taken_out} !== 2'b00) begin n_bad++; $display("FAIL add_flags got=%b exp=00", {bus.illegal_out, bus.branch_taken_out}); end
    tick();
    n_cmp++; if ({bus.res_valid_out, bus.inst_ready_out} !== 2'b01) begin n_bad++; $display("FAIL add_return got=%b exp=01", {bus.res_valid_out, bus.inst_ready_out}); end
  endtask

  task automatic test_sub_srai();
    bus.res_ready_in = 1'b1;
    issue(32'h40208233, 32'h44, 32'd0, 32'd1);        // SUB x4,x1,x2
    tick();
    n_cmp++; if (bus.alu_sel_out !== 4'b1000) begin n_bad++; $display("FAIL sub_sel got=%b exp=1000", bus.alu_sel_out); end
    n_cmp++; if (bus.wb_data_out !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sub_data got=%h exp=ffffffff", bus.wb_data_out); end
    tick();
    issue(32'h4040D293, 32'h48, 32'h8000_0000, 32'd0); // SRAI x5,x1,4
    tick();
    n_cmp++; if (bus.alu_sel_out !== 4'b1101) begin n_bad++; $display("FAIL srai_sel got=%b exp=1101", bus.alu_sel_out); end
    n_cmp++; if (bus.alu_in2_out !== 32'h0000_0404) begin n_bad++; $display("FAIL srai_imm got=%h exp=00000404", bus.alu_in2_out); end
    n_cmp++; if (bus.wb_data_out !== 32'hF800_0000) begin n_bad++; $display("FAIL srai_data got=%h exp=f8000000", bus.wb_data_out); end
    tick();
  endtask

  task automatic test_branch();
    bus.res_ready_in = 1'b1;
    issue(32'hFE20CCE3, 32'h100, 32'hFFFF_FFFF, 32'd1); // BLT -8
    tick();
    n_cmp++; if (bus.alu_sel_out !== 4'b0010) begin n_bad++; $display("FAIL blt_sel got=%b exp=0010", bus.alu_sel_out); end
    n_cmp++; if ({bus.branch_taken_out, bus.wb_en_out} !== 2'b10) begin n_bad++; $display("FAIL blt_taken got=%b exp=10", {bus.branch_taken_out, bus.wb_en_out}); end
    n_cmp++; if (bus.branch_target_out !== 32'hF8) begin n_bad++; $display("FAIL blt_target got=%h exp=000000f8", bus.branch_target_out); end
    tick();
    issue(32'hFE20ECE3, 32'h100, 32'hFFFF_FFFF, 32'd1); // BLTU -8
    tick();
    n_cmp++; if (bus.alu_sel_out !== 4'b0011) begin n_bad++; $display("FAIL bltu_sel got=%b exp=0011", bus.alu_sel_out); end
    n_cmp++; if (bus.branch_taken_out !== 1'b0) begin n_bad++; $display("FAIL bltu_taken got=%b exp=0", bus.branch_taken_out); end
    n_cmp++; if (bus.branch_target_out !== 32'hF8) begin n_bad++; $display("FAIL bltu_target got=%h exp=000000f8", bus.branch_target_out); end
    tick();
    issue(32'h00208863, 32'h200, 32'hDEAD_BEEF, 32'hDEAD_BEEF); // BEQ +16
    tick();
    n_cmp++; if (bus.alu_sel_out !== 4'b0100) begin n_bad++; $display("FAIL beq_sel got=%b exp=0100", bus.alu_sel_out); end
    n_cmp++; if (bus.branch_taken_out !== 1'b1) begin n_bad++; $display("FAIL beq_taken got=%b exp=1", bus.branch_taken_out); end
    n_cmp++; if (bus.branch_target_out !== 32'h210) begin n_bad++; $display("FAIL beq_target got=%h exp=00000210", bus.branch_target_out); end
    tick();
    issue(32'h00209863, 32'h200, 32'hDEAD_BEEF, 32'hDEAD_BEEF); // BNE +16
    tick();
    n_cmp++; if ({bus.alu_sel_out, bus.branch_taken_out} !== 5'b01000) begin n_bad++; $display("FAIL bne_taken got=%b exp=01000", {bus.alu_sel_out, bus.branch_taken_out}); end
    tick();
  endtask

  task automatic test_stall();
    bus.res_ready_in = 1'b0;
    issue(32'h002081B3, 32'h60, 32'd10, 32'd20);
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({bus.res_valid_out, bus.inst_ready_out, bus.wb_en_out, bus.wb_rd_out, bus.wb_data_out} !== {3'b101, 5'd3, 32'd30}) begin
        n_bad++;
        $display("FAIL stall_hold cyc=%0d got=%b%b%b/%0d/%h exp=101/3/0000001e", i,
                 bus.res_valid_out, bus.inst_ready_out, bus.wb_en_out, bus.wb_rd_out, bus.wb_data_out);
      end
      tick();
    end
    bus.res_ready_in = 1'b1;
    tick();
    n_cmp++; if ({bus.res_valid_out, bus.inst_ready_out} !== 2'b01) begin n_bad++; $display("FAIL stall_release got=%b exp=01", {bus.res_valid_out, bus.inst_ready_out}); end
  endtask

  task automatic test_flush();
    bus.res_ready_in = 1'b0;
    issue(32'h002081B3, 32'h70, 32'd1, 32'd2);
    tick();
    bus.flush_in = 1'b1; bus.res_ready_in = 1'b1;
    tick();
    bus.flush_in = 1'b0;
    n_cmp++; if ({bus.res_valid_out, bus.wb_en_out} !== 2'b00) begin n_bad++; $display("FAIL flush_done got=%b exp=00", {bus.res_valid_out, bus.wb_en_out}); end
    n_cmp++; if (bus.wb_data_out !== 32'd0) begin n_bad++; $display("FAIL flush_data got=%h exp=0", bus.wb_data_out); end
    // Flush in IDLE together with a valid instruction: nothing starts.
    bus.instr_in = 32'h002081B3; bus.rs1_data_in = 32'd3; bus.rs2_data_in = 32'd4;
    bus.inst_valid_in = 1'b1; bus.flush_in = 1'b1;
    tick();
    bus.inst_valid_in = 1'b0; bus.flush_in = 1'b0;
    tick(); tick();
    n_cmp++; if ({bus.res_valid_out, bus.inst_ready_out} !== 2'b01) begin n_bad++; $display("FAIL flush_idle got=%b exp=01", {bus.res_valid_out, bus.inst_ready_out}); end
    n_cmp++; if (bus.alu_in1_out !== 32'd0) begin n_bad++; $display("FAIL flush_idle_in1 got=%h exp=0", bus.alu_in1_out); end
  endtask

  task automatic test_illegal();
    bus.res_ready_in = 1'b1;
    issue(32'h022081B3, 32'h80, 32'd6, 32'd7);        // MUL
    n_cmp++; if (bus.alu_sel_out !== 4'b0000) begin n_bad++; $display("FAIL mul_sel got=%b exp=0000", bus.alu_sel_out); end
    tick();
    n_cmp++; if ({bus.illegal_out, bus.wb_en_out, bus.branch_taken_out} !== 3'b100) begin n_bad++; $display("FAIL mul_ill got=%b exp=100", {bus.illegal_out, bus.wb_en_out, bus.branch_taken_out}); end
    tick();
    issue(32'h0000A183, 32'h84, 32'd6, 32'd7);        // LW (unsupported)
    tick();
    n_cmp++; if ({bus.illegal_out, bus.wb_en_out} !== 2'b10) begin n_bad++; $display("FAIL lw_ill got=%b exp=10", {bus.illegal_out, bus.wb_en_out}); end
    tick();
    issue(32'h00508013, 32'h88, 32'd9, 32'd0);        // ADDI x0,x1,5
    tick();
    n_cmp++; if ({bus.illegal_out, bus.wb_en_out, bus.res_valid_out} !== 3'b001) begin n_bad++; $display("FAIL addi_x0 got=%b exp=001", {bus.illegal_out, bus.wb_en_out, bus.res_valid_out}); end
    n_cmp++; if (bus.wb_data_out !== 32'd14) begin n_bad++; $display("FAIL addi_x0_data got=%h exp=0000000e", bus.wb_data_out); end
    tick();
  endtask

  task automatic test_rst_mid();
    bus.res_ready_in = 1'b1;
    issue(32'h002081B3, 32'h90, 32'd5, 32'd7);
    rst = 1'b1; bus.flush_in = 1'b1;
    tick();
    rst = 1'b0; bus.flush_in = 1'b0;
    n_cmp++; if ({bus.res_valid_out, bus.wb_en_out, bus.illegal_out, bus.branch_taken_out} !== 4'b0000) begin n_bad++; $display("FAIL rstmid_flags got=%b exp=0000", {bus.res_valid_out, bus.wb_en_out, bus.illegal_out, bus.branch_taken_out}); end
    n_cmp++; if ({bus.alu_in1_out, bus.alu_in2_out, bus.alu_sel_out} !== 68'd0) begin n_bad++; $display("FAIL rstmid_alu got=%h exp=0", {bus.alu_in1_out, bus.alu_in2_out, bus.alu_sel_out}); end
    tick();
    n_cmp++; if ({bus.res_valid_out, bus.wb_data_out, bus.branch_target_out} !== 65'd0) begin n_bad++; $display("FAIL rstmid_stay got=%h exp=0", {bus.res_valid_out, bus.wb_data_out, bus.branch_target_out}); end
  endtask

  initial begin
    bus.inst_valid_in = 1'b0;
    bus.instr_in      = 32'h0;
    bus.pc_in         = 32'h0;
    bus.rs1_data_in   = 32'h0;
    bus.rs2_data_in   = 32'h0;
    bus.flush_in      = 1'b0;
    bus.res_ready_in  = 1'b0;
    test_reset();
    test_add();
    test_sub_srai();
    test_branch();
    test_stall();
    test_flush();
    test_illegal();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
